// File: rtl/motor_ctrl_seq.sv
// ---------------------------------------------------------------------------
// motor_ctrl_seq
//   Robot drive controller. Debounces the on/off buttons and the four motion
//   commands, runs an OFF/RUN/FAULT state machine, drives a two-wheel H-bridge
//   with a dead-time gap on every direction reversal, and drives the status
//   LEDs, the LED matrix and the 7-segment digit blanking. Every output is a
//   flop.
//
//   Build option: FAULT_LATCH_EN
//     defined   - FAULT is held until the power-off button is pressed.
//     undefined - FAULT falls back to RUN once the conflicting commands clear.
//
// Ports
//   Clk            in   system clock
//   Rst_n          in   asynchronous active-low reset
//   L, B           in   power-on / power-off buttons (async, active-high)
//   E, D, F, A     in   turn left, turn right, forward, reverse (async)
//   Gre, Red       out  green LED (RUN), red LED (OFF and FAULT)
//   Re, Rd         out  left / right wheel forward drive, MOT_W copies
//   R_Re, R_Rd     out  left / right wheel reverse drive, MOT_W copies
//   Erro           out  error LEDs, blink in FAULT
//   Col, Lin       out  matrix columns (1 = on), rows (0 = on)
//   DigOff         out  digit blanking, 1 = digit off
// ---------------------------------------------------------------------------
module motor_ctrl_seq #(
    parameter int DEB_CYCLES  = 4,
    parameter int DEAD_CYCLES = 3,
    parameter int BLINK_DIV   = 8,
    parameter int MOT_W       = 2,
    parameter int N_COLS      = 5,
    parameter int N_ROWS      = 5,
    parameter int N_DIG       = 4,
    parameter int ERR_W       = 3
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              L,
    input  logic              B,
    input  logic              E,
    input  logic              D,
    input  logic              F,
    input  logic              A,
    output logic              Gre,
    output logic              Red,
    output logic [MOT_W-1:0]  Re,
    output logic [MOT_W-1:0]  Rd,
    output logic [MOT_W-1:0]  R_Re,
    output logic [MOT_W-1:0]  R_Rd,
    output logic [ERR_W-1:0]  Erro,
    output logic [N_COLS-1:0] Col,
    output logic [N_ROWS-1:0] Lin,
    output logic [N_DIG-1:0]  DigOff
);

    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int DEAD_W  = $clog2(DEAD_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    // Input vector bit positions
    localparam int IX_A = 0, IX_F = 1, IX_D = 2, IX_E = 3, IX_B = 4, IX_L = 5;

    typedef enum logic [1:0] {S_OFF, S_RUN, S_FAULT} state_t;

    logic [5:0] w_raw;
    logic [5:0] w_deb;
    assign w_raw = {L, B, E, D, F, A};

    // ---------------- synchroniser + counter debounce per input -------------
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_in
            logic             r_sync1, r_sync2, r_deb;
            logic [DEB_W-1:0] r_cnt;
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    // Count consecutive samples that disagree with the
                    // accepted value; any agreeing sample restarts the run.
                    if (r_sync2 != r_deb) begin
                        if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                            r_deb <= r_sync2;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end
            assign w_deb[gi] = r_deb;
        end
    endgenerate

    // ---------------- button edges and conflict detect ----------------------
    logic r_l_d, r_b_d;
    logic w_lp, w_bp, w_pre;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_l_d <= 1'b0;
            r_b_d <= 1'b0;
        end else begin
            r_l_d <= w_deb[IX_L];
            r_b_d <= w_deb[IX_B];
        end
    end

    assign w_lp  = w_deb[IX_L] & ~r_l_d;
    assign w_bp  = w_deb[IX_B] & ~r_b_d;
    assign w_pre = (w_deb[IX_E] & w_deb[IX_D]) | (w_deb[IX_F] & w_deb[IX_A]);

    // ---------------- FSM --------------------------------------------------
    state_t r_state, w_state_next;
    logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_next;
    logic               r_lit, w_lit_next;
    logic               w_run_next;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= S_OFF;
            r_blink_cnt <= '0;
            r_lit       <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_blink_cnt <= w_blink_cnt_next;
            r_lit       <= w_lit_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_OFF: begin
                // The off button beats a simultaneous on press.
                if (!w_bp && w_lp)
                    w_state_next = w_pre ? S_FAULT : S_RUN;
            end
            S_RUN: begin
                if (w_bp)
                    w_state_next = S_OFF;
                else if (w_pre)
                    w_state_next = S_FAULT;
            end
            S_FAULT: begin
`ifdef FAULT_LATCH_EN
                if (w_bp)
                    w_state_next = S_OFF;
`else
                if (w_bp)
                    w_state_next = S_OFF;
                else if (!w_pre)
                    w_state_next = S_RUN;
`endif
            end
            default: w_state_next = S_OFF;
        endcase
    end

    assign w_run_next = (w_state_next == S_RUN);

    // Blink phase restarts lit on every state change so FAULT entry is lit.
    always_comb begin
        w_blink_cnt_next = r_blink_cnt;
        w_lit_next       = r_lit;
        if (w_state_next != r_state) begin
            w_blink_cnt_next = '0;
            w_lit_next       = 1'b1;
        end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            w_blink_cnt_next = '0;
            w_lit_next       = ~r_lit;
        end else begin
            w_blink_cnt_next = r_blink_cnt + 1'b1;
        end
    end

    // ---------------- wheel requests (index 0 = left, 1 = right) ------------
    logic [1:0] w_req_fwd, w_req_rev;

    always_comb begin
        w_req_fwd = 2'b00;
        w_req_rev = 2'b00;
        if (w_run_next) begin
            if (w_deb[IX_A])      w_req_rev = 2'b11;
            else if (w_deb[IX_E]) w_req_fwd = 2'b10;  // turn left: right wheel only
            else if (w_deb[IX_D]) w_req_fwd = 2'b01;  // turn right: left wheel only
            else if (w_deb[IX_F]) w_req_fwd = 2'b11;
        end
    end

    logic [1:0] w_fwd, w_rev;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_wheel
            logic              r_fwd, r_rev, r_dead;
            logic [DEAD_W-1:0] r_dead_cnt;
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    r_fwd      <= 1'b0;
                    r_rev      <= 1'b0;
                    r_dead     <= 1'b0;
                    r_dead_cnt <= '0;
                end else if (!w_run_next) begin
                    // Leaving RUN stops at once and abandons any dead time.
                    r_fwd      <= 1'b0;
                    r_rev      <= 1'b0;
                    r_dead     <= 1'b0;
                    r_dead_cnt <= '0;
                end else if (r_dead) begin
                    // Whatever is requested at expiry is what gets applied.
                    if (r_dead_cnt == DEAD_W'(DEAD_CYCLES - 1)) begin
                        r_dead     <= 1'b0;
                        r_dead_cnt <= '0;
                        r_fwd      <= w_req_fwd[gi];
                        r_rev      <= w_req_rev[gi];
                    end else begin
                        r_dead_cnt <= r_dead_cnt + 1'b1;
                    end
                end else if ((r_fwd && w_req_rev[gi]) || (r_rev && w_req_fwd[gi])) begin
                    r_fwd      <= 1'b0;
                    r_rev      <= 1'b0;
                    r_dead     <= 1'b1;
                    r_dead_cnt <= '0;
                end else begin
                    r_fwd <= w_req_fwd[gi];
                    r_rev <= w_req_rev[gi];
                end
            end
            assign w_fwd[gi] = r_fwd;
            assign w_rev[gi] = r_rev;
        end
    endgenerate

    assign Re   = {MOT_W{w_fwd[0]}};
    assign Rd   = {MOT_W{w_fwd[1]}};
    assign R_Re = {MOT_W{w_rev[0]}};
    assign R_Rd = {MOT_W{w_rev[1]}};

    // ---------------- LEDs / display -------------------------------------
    logic              r_gre, r_red;
    logic [ERR_W-1:0]  r_erro;
    logic [N_COLS-1:0] r_col;
    logic [N_ROWS-1:0] r_lin;
    logic [N_DIG-1:0]  r_digoff;
    logic              w_fault_lit_next, w_matrix_on_next;
    logic [N_DIG-1:0]  w_digoff_next;

    assign w_fault_lit_next = (w_state_next == S_FAULT) && w_lit_next;
    assign w_matrix_on_next = w_run_next || w_fault_lit_next;

    always_comb begin
        w_digoff_next    = '1;
        w_digoff_next[0] = ~w_run_next;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_gre    <= 1'b0;
            r_red    <= 1'b1;
            r_erro   <= '0;
            r_col    <= '0;
            r_lin    <= '1;
            r_digoff <= '1;
        end else begin
            r_gre    <= w_run_next;
            r_red    <= ~w_run_next;
            r_erro   <= w_fault_lit_next ? '1 : '0;
            r_col    <= w_matrix_on_next ? '1 : '0;
            r_lin    <= w_matrix_on_next ? '0 : '1;
            r_digoff <= w_digoff_next;
        end
    end

    assign Gre    = r_gre;
    assign Red    = r_red;
    assign Erro   = r_erro;
    assign Col    = r_col;
    assign Lin    = r_lin;
    assign DigOff = r_digoff;

endmodule

// File: tb/tb_motor_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_motor_ctrl_seq
//   Directed bench for motor_ctrl_seq at DEB_CYCLES=4, DEAD_CYCLES=3,
//   BLINK_DIV=8. Inputs change on the falling edge; outputs are sampled on
//   the falling edge, so "N steps" means N rising edges after the change.
//   Observed outputs are packed as {Red,Gre,Re,Rd,R_Re,R_Rd,Erro,Col,Lin,DigOff}.
// ---------------------------------------------------------------------------
module tb_motor_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       L = 1'b0, B = 1'b0, E = 1'b0, D = 1'b0, F = 1'b0, A = 1'b0;
    logic       Gre, Red;
    logic [1:0] Re, Rd, R_Re, R_Rd;
    logic [2:0] Erro;
    logic [4:0] Col, Lin;
    logic [3:0] DigOff;

    int tests = 0;
    int fails = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    motor_ctrl_seq #(
        .DEB_CYCLES(4), .DEAD_CYCLES(3), .BLINK_DIV(8), .MOT_W(2),
        .N_COLS(5), .N_ROWS(5), .N_DIG(4), .ERR_W(3)
    ) dut (
        .Clk(clk), .Rst_n(rst_n),
        .L(L), .B(B), .E(E), .D(D), .F(F), .A(A),
        .Gre(Gre), .Red(Red),
        .Re(Re), .Rd(Rd), .R_Re(R_Re), .R_Rd(R_Rd),
        .Erro(Erro), .Col(Col), .Lin(Lin), .DigOff(DigOff)
    );

    logic [26:0] all_out;
    assign all_out = {Red, Gre, Re, Rd, R_Re, R_Rd, Erro, Col, Lin, DigOff};

    // Motor byte is {Re,Rd,R_Re,R_Rd}
    localparam logic [26:0] OUT_OFF   = {1'b1, 1'b0, 8'h00, 3'b000, 5'h00, 5'h1F, 4'hF};
    localparam logic [26:0] OUT_F_LIT = {1'b1, 1'b0, 8'h00, 3'b111, 5'h1F, 5'h00, 4'hF};
    localparam logic [26:0] OUT_F_DRK = {1'b1, 1'b0, 8'h00, 3'b000, 5'h00, 5'h1F, 4'hF};

    function automatic logic [26:0] run_out(input logic [7:0] m);
        return {1'b0, 1'b1, m, 3'b000, 5'h1F, 5'h00, 4'hE};
    endfunction

    // A wheel must never be driven both ways at once.
    always @(negedge clk)
        if (rst_n && (((Re & R_Re) | (Rd & R_Rd)) != 2'b00)) overlap++;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        tests++; if (all_out !== OUT_OFF) begin fails++; $display("FAIL reset_state: got %h want %h", all_out, OUT_OFF); end
        step(5);
        tests++; if (all_out !== OUT_OFF) begin fails++; $display("FAIL reset_idle: got %h want %h", all_out, OUT_OFF); end
        $display("[TB] reset: outputs %h", all_out);
    endtask

    task automatic test_glitch;
        L = 1'b1;
        step(3);
        L = 1'b0;
        step(12);
        tests++; if (all_out !== OUT_OFF) begin fails++; $display("FAIL glitch_rejected: got %h want %h", all_out, OUT_OFF); end
        $display("[TB] glitch: 3-cycle L pulse, outputs %h", all_out);
    endtask

    task automatic test_power_on;
        L = 1'b1;
        step(6);
        tests++; if (all_out !== OUT_OFF) begin fails++; $display("FAIL power_on_early: got %h want %h", all_out, OUT_OFF); end
        step(1);
        tests++; if (all_out !== run_out(8'h00)) begin fails++; $display("FAIL power_on_7: got %h want %h", all_out, run_out(8'h00)); end
        step(3);
        L = 1'b0;
        step(10);
        tests++; if (all_out !== run_out(8'h00)) begin fails++; $display("FAIL power_on_hold: got %h want %h", all_out, run_out(8'h00)); end
        $display("[TB] power_on: Gre=%b", Gre);
    endtask

    task automatic test_turn;
        E = 1'b1;
        step(6);
        tests++; if (all_out !== run_out(8'h00)) begin fails++; $display("FAIL turn_e_early: got %h want %h", all_out, run_out(8'h00)); end
        step(1);
        tests++; if (all_out !== run_out(8'h30)) begin fails++; $display("FAIL turn_e: got %h want %h", all_out, run_out(8'h30)); end
        E = 1'b0; D = 1'b1;
        step(7);
        tests++; if (all_out !== run_out(8'hC0)) begin fails++; $display("FAIL turn_d: got %h want %h", all_out, run_out(8'hC0)); end
        D = 1'b0;
        step(7);
        tests++; if (all_out !== run_out(8'h00)) begin fails++; $display("FAIL turn_stop: got %h want %h", all_out, run_out(8'h00)); end
        $display("[TB] turn: E then D then stop, outputs %h", all_out);
    endtask

    task automatic test_forward;
        F = 1'b1;
        step(6);
        tests++; if (all_out !== run_out(8'h00)) begin fails++; $display("FAIL fwd_early: got %h want %h", all_out, run_out(8'h00)); end
        step(1);
        tests++; if (all_out !== run_out(8'hF0)) begin fails++; $display("FAIL fwd_7: got %h want %h", all_out, run_out(8'hF0)); end
        $display("[TB] forward: Re=%b Rd=%b", Re, Rd);
    endtask

    task automatic test_reversal;
        F = 1'b0; A = 1'b1;
        step(6);
        tests++; if (all_out !== run_out(8'hF0)) begin fails++; $display("FAIL rev_still_fwd: got %h want %h", all_out, run_out(8'hF0)); end
        step(1);
        tests++; if (all_out !== run_out(8'h00)) begin fails++; $display("FAIL rev_dead_1: got %h want %h", all_out, run_out(8'h00)); end
        step(2);
        tests++; if (all_out !== run_out(8'h00)) begin fails++; $display("FAIL rev_dead_3: got %h want %h", all_out, run_out(8'h00)); end
        step(1);
        tests++; if (all_out !== run_out(8'h0F)) begin fails++; $display("FAIL rev_applied: got %h want %h", all_out, run_out(8'h0F)); end
        $display("[TB] reversal: R_Re=%b R_Rd=%b", R_Re, R_Rd);
    endtask

    task automatic test_fault;
        A = 1'b0; E = 1'b1; D = 1'b1;
        step(6);
        tests++; if (all_out !== run_out(8'h0F)) begin fails++; $display("FAIL fault_early: got %h want %h", all_out, run_out(8'h0F)); end
        step(1);
        tests++; if (all_out !== OUT_F_LIT) begin fails++; $display("FAIL fault_entry: got %h want %h", all_out, OUT_F_LIT); end
        step(7);
        tests++; if (all_out !== OUT_F_LIT) begin fails++; $display("FAIL fault_lit_end: got %h want %h", all_out, OUT_F_LIT); end
        step(1);
        tests++; if (all_out !== OUT_F_DRK) begin fails++; $display("FAIL fault_dark: got %h want %h", all_out, OUT_F_DRK); end
        step(7);
        tests++; if (all_out !== OUT_F_DRK) begin fails++; $display("FAIL fault_dark_end: got %h want %h", all_out, OUT_F_DRK); end
        step(1);
        tests++; if (all_out !== OUT_F_LIT) begin fails++; $display("FAIL fault_relit: got %h want %h", all_out, OUT_F_LIT); end
        $display("[TB] fault: Erro=%b", Erro);
    endtask

    task automatic test_fault_clear;
        E = 1'b0; D = 1'b0;
        step(7);
`ifdef FAULT_LATCH_EN
        tests++; if ({Red, Gre, DigOff} !== 6'b10_1111) begin fails++; $display("FAIL fault_latched: got %b want %b", {Red, Gre, DigOff}, 6'b10_1111); end
`else
        tests++; if (all_out !== run_out(8'h00)) begin fails++; $display("FAIL fault_auto_run: got %h want %h", all_out, run_out(8'h00)); end
`endif
        B = 1'b1;
        step(7);
        tests++; if (all_out !== OUT_OFF) begin fails++; $display("FAIL fault_b_off: got %h want %h", all_out, OUT_OFF); end
        B = 1'b0;
        step(10);
        $display("[TB] fault_clear: outputs %h", all_out);
    endtask

    task automatic test_lb_same;
        L = 1'b1;
        step(7);
        tests++; if (all_out !== run_out(8'h00)) begin fails++; $display("FAIL lb_run: got %h want %h", all_out, run_out(8'h00)); end
        L = 1'b0;
        step(10);
        L = 1'b1; B = 1'b1;
        step(6);
        tests++; if (all_out !== run_out(8'h00)) begin fails++; $display("FAIL lb_early: got %h want %h", all_out, run_out(8'h00)); end
        step(1);
        tests++; if (all_out !== OUT_OFF) begin fails++; $display("FAIL lb_off: got %h want %h", all_out, OUT_OFF); end
        L = 1'b0; B = 1'b0;
        step(10);
        tests++; if (all_out !== OUT_OFF) begin fails++; $display("FAIL lb_stays_off: got %h want %h", all_out, OUT_OFF); end
        $display("[TB] lb_same: outputs %h", all_out);
    endtask

    task automatic test_reset_mid;
        L = 1'b1;
        step(7);
        L = 1'b0; F = 1'b1;
        step(10);
        tests++; if (all_out !== run_out(8'hF0)) begin fails++; $display("FAIL mid_fwd: got %h want %h", all_out, run_out(8'hF0)); end
        F = 1'b0; A = 1'b1;
        step(8);
        tests++; if (all_out !== run_out(8'h00)) begin fails++; $display("FAIL mid_dead: got %h want %h", all_out, run_out(8'h00)); end
        rst_n = 1'b0;
        #1;
        tests++; if (all_out !== OUT_OFF) begin fails++; $display("FAIL mid_reset_async: got %h want %h", all_out, OUT_OFF); end
        A = 1'b0;
        @(negedge clk);
        step(2);
        rst_n = 1'b1;
        step(10);
        tests++; if (all_out !== OUT_OFF) begin fails++; $display("FAIL mid_after_reset: got %h want %h", all_out, OUT_OFF); end
        $display("[TB] reset_mid: outputs %h", all_out);
    endtask

    task automatic test_no_overlap;
        tests++; if (overlap !== 0) begin fails++; $display("FAIL no_overlap: got %0d want %0d", overlap, 0); end
        $display("[TB] no_overlap: %0d overlapping cycles", overlap);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_glitch;
        test_power_on;
        test_turn;
        test_forward;
        test_reversal;
        test_fault;
        test_fault_clear;
        test_lb_same;
        test_reset_mid;
        test_no_overlap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
